if_id_buf: RTL and testbench
============================

IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 16'h0800, instruction word presented to decode when no valid entry exists.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-low (asserted when rst==0).
REQ-004 SHALL have port fetch_valid  input  1  fetch presents an instruction this cycle.
REQ-005 SHALL have port fetch_instr  input  16  instruction word read at fetch_pc.
REQ-006 SHALL have port fetch_pc  input  16  address of fetch_instr.
REQ-007 SHALL have port fetch_ready  output  1  buffer accepts a push this cycle; fetch holds its PC when low.
REQ-008 SHALL have port flush  input  1  branch/jump resolved taken; discard all buffered instructions.
REQ-009 SHALL have port id_ready  input  1  decode consumes the head entry this cycle.
REQ-010 SHALL have port id_valid  output  1  head entry is valid.
REQ-011 SHALL have port id_instr  output  16  head instruction, or NOP_INSTR when id_valid==0.
REQ-012 SHALL have port id_pc  output  16  head PC, or 16'h0000 when id_valid==0.
REQ-013 SHALL have port id_pc_inc  output  16  id_pc + 2, modulo 2^16.
REQ-014 SHALL have port count  output  2  occupancy, 0..2.
REQ-015 SHALL have port halted  output  1  a HALT (opcode bits [15:11]==5'b00000) has been accepted and not flushed.

Function
REQ-016 SHALL be a 2-entry FIFO of {instr, pc}, with read and write pointers wrapping 1->0.
REQ-017 SHALL drive fetch_ready = (count<2) & ~halted, with no combinational path from id_ready or flush.
REQ-018 SHALL push when fetch_valid & fetch_ready & ~flush; a push attempted while fetch_ready==0 SHALL be dropped with no state change.
REQ-019 SHALL pop when id_ready & id_valid & ~flush; id_ready while empty SHALL be ignored.
REQ-020 SHALL keep count unchanged on a simultaneous push and pop (count==1 case); count==2 cannot push.
REQ-021 SHALL drive id_valid, id_instr, id_pc and id_pc_inc combinationally from the head entry, giving zero-cycle latency when not empty: an instruction pushed in cycle N is visible on id_* in cycle N+1.
REQ-022 SHALL preserve order: entries leave in push order.
REQ-023 SHALL set halted in the cycle after a pushed instruction has opcode 5'b00000; no further pushes SHALL be accepted while halted==1; already-buffered entries SHALL still drain.
REQ-024 SHALL, on flush, give flush priority over push and pop: next cycle count=0, pointers=0, halted=0, id_valid=0; the same-cycle push is discarded.
REQ-025 SHALL, while halted==1 and the FIFO is empty, hold id_instr=NOP_INSTR indefinitely until flush or reset.
REQ-026 SHALL compute id_pc_inc with 16-bit wrap (16'hFFFE -> 16'h0000).

Reset
REQ-027 SHALL, while rst==0, immediately (without a clock edge) force count=0, pointers=0, halted=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_inc=16'h0002, and fetch_ready=1 once rst releases.
REQ-028 SHALL, on reset asserted mid-operation, discard all entries and any in-flight push; storage contents need not be cleared.
REQ-029 SHALL treat the first rising clk edge after rst returns to 1 as an ordinary cycle.

Verification
REQ-030 SHALL cover in-order pass-through: push 16'h4001@pc0, then 16'h4102@pc2, with id_ready=1 -> id_* show 4001/0000/0002, then 4102/0002/0004, with count<=1.
REQ-031 SHALL cover fill with backpressure: id_ready=0, push three words -> count=2, fetch_ready=0, third word dropped; then id_ready=1 -> first two words emerge in order.
REQ-032 SHALL cover simultaneous push+pop at count==1 -> count stays 1, and the head advances to the next entry.
REQ-033 SHALL cover flush with count=2 and a concurrent push -> next cycle count=0, id_instr=16'h0800, pushed word absent.
REQ-034 SHALL cover HALT: push 16'h0000 -> halted=1, fetch_ready=0, buffered entries drain, id_instr then stays 16'h0800; a subsequent flush clears halted.
REQ-035 SHALL cover async reset: drop rst between clock edges with count=2 -> outputs take their REQ-027 values before the next edge; fetch_pc=16'hFFFE pushed after reset -> id_pc_inc=16'h0000.

Source files
------------

// File: rtl/if_id_buf.sv
// Two-entry instruction buffer between fetch and decode.
// Decode sees the head entry with no added latency; HALT stops further pushes until a flush.
module if_id_buf #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_instr,
    input  logic [15:0] fetch_pc,
    output logic        fetch_ready,
    input  logic        flush,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_inc,
    output logic [1:0]  count,
    output logic        halted
);

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    typedef struct packed {
        logic [W-1:0] instr;
        logic [W-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [CW-1:0] count_q;
    logic          halted_q;
    logic          push;
    logic          pop;
    logic          push_is_halt;
    entry_t        head;

    // Ready depends only on registered state, never on flush or id_ready.
    assign fetch_ready  = (count_q < CW'(DEPTH)) & ~halted_q;
    assign push         = fetch_valid & fetch_ready & ~flush;
    assign pop          = id_ready & id_valid & ~flush;
    assign push_is_halt = (fetch_instr[W-1:W-5] == 5'b00000);

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: fetch_instr, pc: fetch_pc};
        end
    end

    // Pointers, occupancy and halt flag; flush outranks push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push && push_is_halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Head presentation; an empty buffer shows a NOP at PC 0.
    assign head      = mem[rd_ptr];
    assign id_valid  = (count_q != '0);
    assign id_instr  = id_valid ? head.instr : NOP_INSTR;
    assign id_pc     = id_valid ? head.pc : W'(0);
    assign id_pc_inc = id_pc + W'(2);
    assign count     = count_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: directed scenarios then random traffic against a queue-based model.
module tb_if_id_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [15:0] fetch_instr;
    logic [15:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_inc;
    logic [1:0]  count;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: FIFO as a queue of {instr, pc} plus a halt flag.
    logic [31:0] mq[$];
    bit          m_halted = 1'b0;

    if_id_buf #(.NOP_INSTR(16'h0800)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_pc   (fetch_pc),
        .fetch_ready(fetch_ready),
        .flush      (flush),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc_inc  (id_pc_inc),
        .count      (count),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic idr, input logic fl);
        fetch_valid = v;
        fetch_instr = ins;
        fetch_pc    = pc;
        id_ready    = idr;
        flush       = fl;
    endtask

    task automatic model_step();
        bit rdy;
        rdy = (mq.size() < 2) && !m_halted;
        if (flush) begin
            mq.delete();
            m_halted = 1'b0;
        end else begin
            if (id_ready && mq.size() > 0) void'(mq.pop_front());
            if (fetch_valid && rdy) begin
                mq.push_back({fetch_instr, fetch_pc});
                if (fetch_instr[15:11] == 5'b00000) m_halted = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e_instr, e_pc, e_inc;
        logic        e_valid;
        e_valid = (mq.size() > 0);
        e_instr = e_valid ? mq[0][31:16] : 16'h0800;
        e_pc    = e_valid ? mq[0][15:0] : 16'h0000;
        e_inc   = e_pc + 16'd2;
        chk({tag, ".id_valid"},    16'(id_valid),    16'(e_valid));
        chk({tag, ".id_instr"},    id_instr,         e_instr);
        chk({tag, ".id_pc"},       id_pc,            e_pc);
        chk({tag, ".id_pc_inc"},   id_pc_inc,        e_inc);
        chk({tag, ".count"},       16'(count),       16'(mq.size()));
        chk({tag, ".halted"},      16'(halted),      16'(m_halted));
        chk({tag, ".fetch_ready"}, 16'(fetch_ready), 16'((mq.size() < 2) && !m_halted));
    endtask

    // One clock: model consumes the inputs present at the edge, outputs sampled 1 time unit later.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #12;
        check_all("reset");
        chk("reset.pc_inc_lit", id_pc_inc, 16'h0002);
        chk("reset.instr_lit",  id_instr,  16'h0800);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset.ready_lit", 16'(fetch_ready), 16'h0001);

        // In-order pass-through with decode always ready.
        drive(1'b1, 16'h4001, 16'h0000, 1'b1, 1'b0);
        tick("pass0");
        chk("pass0.instr_lit", id_instr, 16'h4001);
        chk("pass0.inc_lit",   id_pc_inc, 16'h0002);
        drive(1'b1, 16'h4102, 16'h0002, 1'b1, 1'b0);
        tick("pass1");
        chk("pass1.instr_lit", id_instr, 16'h4102);
        chk("pass1.pc_lit",    id_pc, 16'h0002);
        chk("pass1.inc_lit",   id_pc_inc, 16'h0004);
        chk("pass1.count_lit", 16'(count), 16'h0001);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick("pass2");

        // Fill under backpressure; the third word is dropped.
        drive(1'b1, 16'h4010, 16'h0010, 1'b0, 1'b0);
        tick("fill0");
        drive(1'b1, 16'h4012, 16'h0012, 1'b0, 1'b0);
        tick("fill1");
        chk("fill1.count_lit", 16'(count), 16'h0002);
        chk("fill1.ready_lit", 16'(fetch_ready), 16'h0000);
        drive(1'b1, 16'h4014, 16'h0014, 1'b0, 1'b0);
        tick("fill2");
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick("drain0");
        chk("drain0.instr_lit", id_instr, 16'h4012);
        tick("drain1");
        chk("drain1.instr_lit", id_instr, 16'h0800);

        // Simultaneous push and pop at count 1.
        drive(1'b1, 16'h4020, 16'h0020, 1'b0, 1'b0);
        tick("pp0");
        drive(1'b1, 16'h4022, 16'h0022, 1'b1, 1'b0);
        tick("pp1");
        chk("pp1.count_lit", 16'(count), 16'h0001);
        chk("pp1.instr_lit", id_instr, 16'h4022);

        // Flush at count 2 with a concurrent push.
        drive(1'b1, 16'h4024, 16'h0024, 1'b0, 1'b0);
        tick("fl0");
        drive(1'b1, 16'h4026, 16'h0026, 1'b1, 1'b1);
        tick("fl1");
        chk("fl1.count_lit", 16'(count), 16'h0000);
        chk("fl1.instr_lit", id_instr, 16'h0800);

        // HALT: pushes stop, buffer drains, NOP persists until flush.
        drive(1'b1, 16'h4030, 16'h0030, 1'b0, 1'b0);
        tick("halt0");
        drive(1'b1, 16'h0000, 16'h0032, 1'b0, 1'b0);
        tick("halt1");
        chk("halt1.halted_lit", 16'(halted), 16'h0001);
        drive(1'b1, 16'h5555, 16'h0034, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick("halt_drain");
        chk("halt.instr_lit", id_instr, 16'h0800);
        chk("halt.ready_lit", 16'(fetch_ready), 16'h0000);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        tick("halt_flush");
        chk("halt_flush.halted_lit", 16'(halted), 16'h0000);

        // Asynchronous reset between edges with a full buffer.
        drive(1'b1, 16'h4040, 16'h0040, 1'b0, 1'b0);
        tick("ar0");
        drive(1'b1, 16'h4042, 16'h0042, 1'b0, 1'b0);
        tick("ar1");
        drive(1'b1, 16'h4044, 16'h0044, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        mq.delete();
        m_halted = 1'b0;
        check_all("async_rst");
        chk("async_rst.inc_lit", id_pc_inc, 16'h0002);
        #2;
        rst = 1'b1;
        drive(1'b1, 16'h4046, 16'hFFFE, 1'b0, 1'b0);
        tick("wrap");
        chk("wrap.inc_lit", id_pc_inc, 16'h0000);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        tick("wrap_flush");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 39) == 0) ins[15:11] = 5'b00000;
            drive(1'($urandom_range(0, 3) != 0), ins, {16'($urandom) & 16'hFFFE},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 11) == 0));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
